interboard_tx: RTL and testbench
================================

Name: interboard_tx

Overview:
- Serial transmitter for the inter-board link; sits directly downstream of the slave game controller.
- Consumes the controller's ctrl_en / ctrl_msg_type / ctrl_number / transmit outputs.
- Packs each message into one 8-bit word and shifts it out as a UART-style frame on a single wire.
- Returns the inter_ready completion pulse that the controller waits on in its SEND_* states.

Parameters:
CLKS_PER_BIT, 4, clk cycles per serial bit; legal range 2..65535
STOP_BITS, 1, number of stop bits; 1 or 2 only

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset; clock clk
interboard_rst  input  1  synchronous, active-high link abort; same effect as rst except overrun is kept
ctrl_en  input  1  one-cycle request to send {ctrl_number, ctrl_msg_type}
ctrl_msg_type  input  3  message type, sampled when ctrl_en=1
ctrl_number  input  5  number field, sampled when ctrl_en=1
transmit  input  1  controller is in a sending state; gates the inter_ready pulse
tx_serial  output  1  serial line; idle high
inter_ready  output  1  one-cycle pulse when a frame has fully completed
busy  output  1  high from the cycle after acceptance until the frame ends
overrun  output  1  sticky; a ctrl_en arrived while busy

Behaviour:
- Reset values (rst): tx_serial=1, inter_ready=0, busy=0, overrun=0, state=IDLE, all counters=0.
- interboard_rst: same as rst, but overrun is held at its current value.
- Packet word: data[2:0]=ctrl_msg_type, data[7:3]=ctrl_number. Latched into a shift register on acceptance.
- Frame: start bit (0), data[0]..data[7] LSB first, optional parity bit, then STOP_BITS stop bits (1).
  - Each bit is held for exactly CLKS_PER_BIT cycles.
- States and transitions:
  - IDLE -> START on accepted ctrl_en.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY (only when the optional feature is compiled in) or STOP, after 8 bits.
  - PARITY -> STOP after one bit time.
  - STOP -> IDLE after STOP_BITS bit times.
- Counters:
  - Bit-time counter is 16 bits; it wraps to 0 at CLKS_PER_BIT-1.
  - Bit index counter is 3 bits.
- Latency: ctrl_en sampled in cycle 0 -> tx_serial=0 and busy=1 from cycle 1.
  - Frame length N = (1 + 8 + P + STOP_BITS) * CLKS_PER_BIT, where P=1 with parity and 0 without.
  - tx_serial returns to 1 for the stop bit(s); busy falls and state is IDLE in cycle N+1.
- inter_ready:
  - Pulses for one cycle in cycle N+1, registered, only if transmit=1 in cycle N.
  - If transmit=0 in cycle N: the frame still completes untruncated; the pulse is suppressed.
- ctrl_en while busy: request dropped, current frame unaffected, overrun<=1.
- ctrl_en in the same cycle inter_ready pulses: the block is IDLE, so the request is accepted; the next start bit begins the following cycle.
- tx_serial is driven from a register (glitch-free); it is never X after reset.
- Reset or interboard_rst mid-frame: frame abandoned, tx_serial=1 the next cycle, no inter_ready.

Optional Feature:
- Macro: INTERBOARD_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of data[7:0]) is inserted between data[7] and the stop bit(s); P=1.
- Undefined: no parity bit; P=0; the PARITY state and its logic are absent.

Test Plan:
- Reset: hold rst 3 cycles -> tx_serial=1, busy=0, inter_ready=0, overrun=0.
- Basic frame, no parity, CLKS_PER_BIT=4, STOP_BITS=1, transmit=1, ctrl_msg_type=3'b010, ctrl_number=17 (word 8'h8A):
  - ctrl_en pulse at cycle 0 -> line 0 | 0,1,0,1,0,0,0,1 | 1, each bit 4 cycles, starting cycle 1.
  - inter_ready pulse at cycle 41.
- Parity build, same stimulus -> parity bit 1 after data[7]; inter_ready at cycle 45.
- Overrun: ctrl_en again at cycle 10 with number=5 -> original frame bits unchanged, overrun=1, no second frame.
- Back-to-back: ctrl_en asserted in the inter_ready cycle -> second start bit one cycle later; two inter_ready pulses exactly N+1 cycles apart.
- Gating and abort:
  - Drop transmit at cycle 20 -> frame completes, no inter_ready pulse.
  - Separate run: interboard_rst at cycle 15 -> tx_serial=1 from cycle 16, busy=0, overrun unchanged.

Source files
------------

// File: rtl/interboard_tx.sv
// Inter-board serial transmitter: packs {ctrl_number, ctrl_msg_type} into a UART-style frame.
// Define INTERBOARD_TX_PARITY_EN to insert an even-parity bit after data[7].
module interboard_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic       ctrl_en,
    input  logic [2:0] ctrl_msg_type,
    input  logic [4:0] ctrl_number,
    input  logic       transmit,
    output logic       tx_serial,
    output logic       inter_ready,
    output logic       busy,
    output logic       overrun
);

`ifdef INTERBOARD_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [15:0] CNT_MAX   = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        overrun_q, overrun_d;
    logic        bit_done;

    assign bit_done = (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        ready_d   = 1'b0;
        cnt_d     = (state_q == IDLE || bit_done) ? 16'd0 : cnt_q + 16'd1;
        overrun_d = overrun_q | (ctrl_en && state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (ctrl_en) begin
                    data_d  = {ctrl_number, ctrl_msg_type};
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = 3'd0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    tx_d    = data_q[0];
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == 3'd7) begin
`ifdef INTERBOARD_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end
                end
            end
`ifdef INTERBOARD_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    idx_d   = 3'd0;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (idx_q == STOP_LAST) begin
                        // transmit is sampled in the last frame cycle; the pulse lands as the block goes idle
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        ready_d = transmit;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || interboard_rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
        // link abort leaves the sticky overrun flag for the controller to inspect
        if (rst)
            overrun_q <= 1'b0;
        else if (!interboard_rst)
            overrun_q <= overrun_d;
    end

    assign tx_serial   = tx_q;
    assign inter_ready = ready_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_interboard_tx.sv
// Self-checking bench for interboard_tx: random words against a frame-level line model.
module tb_interboard_tx;
    localparam int CPB = 4;
    localparam int SB  = 1;
`ifdef INTERBOARD_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int N = (1 + 8 + P + SB) * CPB;

    logic       clk = 1'b0;
    logic       rst, interboard_rst, ctrl_en, transmit;
    logic [2:0] ctrl_msg_type;
    logic [4:0] ctrl_number;
    logic       tx_serial, inter_ready, busy, overrun;
    int         vectors = 0;
    int         miscompares = 0;

    interboard_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .ctrl_en(ctrl_en),
        .ctrl_msg_type(ctrl_msg_type), .ctrl_number(ctrl_number), .transmit(transmit),
        .tx_serial(tx_serial), .inter_ready(inter_ready), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Line level in cycle c of a frame whose ctrl_en was sampled in cycle 0.
    function automatic logic exp_line(input logic [7:0] w, input int c);
        int b;
        if (c < 1 || c > N) return 1'b1;
        b = (c - 1) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        if (P == 1 && b == 9) return ^w;
        return 1'b1;
    endfunction

    // Sends word w from cycle 0; optionally drops transmit at drop_at and fires a second
    // ctrl_en (number=5) at ovr_at. Checks {tx, busy, ready} every cycle through N+3.
    task automatic run_frame(input string name, input logic [7:0] w, input int drop_at, input int ovr_at);
        logic [2:0] got, exp;
        logic       tx_at_n;
        ctrl_msg_type = w[2:0];
        ctrl_number   = w[7:3];
        ctrl_en       = 1'b1;
        transmit      = 1'b1;
        tx_at_n = !(drop_at > 0 && drop_at <= N);
        for (int c = 1; c <= N + 3; c++) begin
            step();
            got = {tx_serial, busy, inter_ready};
            exp = {exp_line(w, c), (c >= 1 && c <= N), (c == N + 1) && tx_at_n};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL %s word=%h cycle %0d {tx,busy,rdy} got %b want %b", name, w, c, got, exp);
            end
            ctrl_en = (c == ovr_at);
            if (c == ovr_at) begin
                ctrl_msg_type = w[2:0];
                ctrl_number   = 5'd5;
            end
            if (c == drop_at) transmit = 1'b0;
        end
        ctrl_en  = 1'b0;
        transmit = 1'b1;
    endtask

    task automatic test_reset(input string name);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        vectors++;
        if ({tx_serial, busy, inter_ready, overrun} !== 4'b1000) begin
            miscompares++;
            $display("FAIL %s {tx,busy,rdy,ovr} got %b want 1000", name, {tx_serial, busy, inter_ready, overrun});
        end
    endtask

    task automatic test_basic;
        logic [7:0] w;
        run_frame("basic_8A", 8'h8A, 0, 0);
        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            run_frame("basic_rand", w, 0, 0);
        end
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_overrun got %b want 0", overrun);
        end
    endtask

    task automatic test_overrun;
        run_frame("overrun", 8'h8A, 0, 10);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_flag got %b want 1", overrun);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] wa, wb;
        logic [2:0] got, exp;
        logic       line;
        wa = 8'($urandom);
        wb = 8'($urandom);
        ctrl_msg_type = wa[2:0];
        ctrl_number   = wa[7:3];
        ctrl_en       = 1'b1;
        transmit      = 1'b1;
        for (int c = 1; c <= 2 * N + 4; c++) begin
            step();
            line = (c <= N + 1) ? exp_line(wa, c) : exp_line(wb, c - (N + 1));
            exp = {line, (c <= N) || (c >= N + 2 && c <= 2 * N + 1),
                   (c == N + 1) || (c == 2 * N + 2)};
            got = {tx_serial, busy, inter_ready};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL back_to_back cycle %0d {tx,busy,rdy} got %b want %b", c, got, exp);
            end
            ctrl_en = (c == N + 1);
            if (c == N + 1) begin
                ctrl_msg_type = wb[2:0];
                ctrl_number   = wb[7:3];
            end
        end
        ctrl_en = 1'b0;
    endtask

    task automatic test_gating;
        run_frame("gating_20", 8'h8A, 20, 0);
        run_frame("gating_rand", 8'($urandom), int'($urandom_range(1, N)), 0);
    endtask

    task automatic test_abort(input logic ovr_exp);
        logic [2:0] got, exp;
        logic [7:0] w;
        w = 8'h8A;
        ctrl_msg_type = w[2:0];
        ctrl_number   = w[7:3];
        ctrl_en       = 1'b1;
        transmit      = 1'b1;
        for (int c = 1; c <= N + 4; c++) begin
            step();
            got = {tx_serial, busy, inter_ready};
            exp = (c <= 15) ? {exp_line(w, c), 1'b1, 1'b0} : 3'b100;
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL abort cycle %0d {tx,busy,rdy} got %b want %b", c, got, exp);
            end
            ctrl_en        = 1'b0;
            interboard_rst = (c == 15);
        end
        interboard_rst = 1'b0;
        vectors++;
        if (overrun !== ovr_exp) begin
            miscompares++;
            $display("FAIL abort_overrun got %b want %b", overrun, ovr_exp);
        end
        run_frame("after_abort", 8'($urandom), 0, 0);
    endtask

    initial begin
        rst = 1'b0; interboard_rst = 1'b0; ctrl_en = 1'b0; transmit = 1'b1;
        ctrl_msg_type = 3'd0; ctrl_number = 5'd0;
        test_reset("reset");
        test_basic();
        test_overrun();
        test_back_to_back();
        test_gating();
        test_abort(1'b1);
        test_reset("reset_clears_overrun");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
